// File: rtl/clock_enable_scheduler_pkg.sv
// Shared types and constant helpers for the clock-enable scheduler and its arbiter.
// Latency: none; this file holds only types and constant functions.
// Backpressure: not applicable.
package clock_enable_scheduler_pkg;

    // FSM state encoding: IDLE=0, SETUP=1, RUN=2, GAP=3.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Bits needed to encode value distinct states (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/clock_enable_scheduler_rr_arbiter_onehot.sv
// Combinational round-robin pick: first set req bit searching upward from ptr+1, with wrap-around.
// Latency: purely combinational; the result is valid in the same cycle.
// Backpressure: none; the caller decides when the winner is consumed.
// Ports: req (N request bits), ptr (last winner index), winner (one-hot or zero), vld (any request set).
module rr_arbiter_onehot
    import clock_enable_scheduler_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     winner,
    output logic             vld
);

    int best_j;
    int best_d;
    int d;

    always_comb begin
        best_j = 0;
        best_d = N;
        d      = 0;
        vld    = 1'b0;
        winner = '0;
        // d is the search distance of requester j from ptr+1, modulo N;
        // the smallest distance among the set bits wins.
        for (int j = 0; j < N; j++) begin
            d = (j + N - 1 - int'(ptr)) % N;
            if (req[j] && (d < best_d)) begin
                best_d = d;
                best_j = j;
                vld    = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            winner[j] = vld && (j == best_j);
        end
    end

endmodule

// File: rtl/clock_enable_scheduler.sv
// Shares one gated-clock generator among N_REQ requesters: round-robin grant, setup gap, burst of len cycles, guard gap.
// Latency: grant 1 cycle after req; clk_enable rises SETUP_CYC cycles after grant; done pulses on the cycle enable falls.
// Backpressure: requesters hold req until done; a new arbitration happens only after the guard gap, so queued requests simply wait.
// Ports: clk, rst_n (async active-low); req[N_REQ], burst_len[N_REQ*LEN_W], abort in;
//        clk_enable, grant[N_REQ] (one-hot), done[N_REQ] (pulse), busy, aborted (pulse) out; all outputs registered.
module clock_enable_scheduler
    import clock_enable_scheduler_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int LEN_W     = 8,
    parameter int SETUP_CYC = 2,
    parameter int GAP_CYC   = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*LEN_W-1:0] burst_len,
    input  logic                   abort,
    output logic                   clk_enable,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic                   aborted
);

    localparam int PTR_W = clog2(N_REQ);
    localparam int CNT_W = max3(LEN_W, clog2(SETUP_CYC), clog2(GAP_CYC));
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [LEN_W-1:0]   len_q;
    logic [PTR_W-1:0]   ptr;

    logic [N_REQ-1:0]   arb_winner;
    logic               arb_vld;
    logic [PTR_W-1:0]   win_idx;
    logic [LEN_W-1:0]   win_len;

    rr_arbiter_onehot #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req    (req),
        .ptr    (ptr),
        .winner (arb_winner),
        .vld    (arb_vld)
    );

    // Encode the one-hot winner back to an index and pick its length field.
    always_comb begin
        win_idx = '0;
        win_len = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (arb_winner[j]) begin
                win_idx = PTR_W'(j);
                win_len = burst_len[j*LEN_W +: LEN_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            len_q      <= '0;
            ptr        <= PTR_W'(N_REQ - 1);
            clk_enable <= 1'b0;
            grant      <= '0;
            done       <= '0;
            busy       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            done    <= '0;
            aborted <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_vld) begin
                        state <= ST_SETUP;
                        grant <= arb_winner;
                        ptr   <= win_idx;
                        len_q <= win_len;
                        cnt   <= SETUP_LOAD;
                        busy  <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    // Abort or a zero-length burst ends the ownership without
                    // ever raising the enable.
                    if (abort || ((cnt == '0) && (len_q == '0))) begin
                        state   <= ST_GAP;
                        done    <= grant;
                        aborted <= abort;
                        grant   <= '0;
                        cnt     <= GAP_LOAD;
                    end else if (cnt == '0) begin
                        state      <= ST_RUN;
                        clk_enable <= 1'b1;
                        cnt        <= CNT_W'(len_q) - CNT_ONE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (abort || (cnt == '0)) begin
                        state      <= ST_GAP;
                        clk_enable <= 1'b0;
                        done       <= grant;
                        aborted    <= abort;
                        grant      <= '0;
                        cnt        <= GAP_LOAD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_GAP: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    clk_enable <= 1'b0;
                    grant      <= '0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/clock_enable_scheduler.md
Name: clock_enable_scheduler

Overview:
- Shares one gated-clock generator (enable in, free-running half-period toggle out) between N requesters; each requester asks for a burst of a given number of system-clock cycles.
- The block arbitrates requests round-robin and drives the generator enable for exactly the granted burst length.
- It inserts guard gaps so the generated clock always settles low between owners.
- It sits between the NoC-simulation phase controllers and the clock generator instance.

Parameters:
- N_REQ, 4, number of requesters (≥2).
- LEN_W, 8, width of each burst-length field.
- SETUP_CYC, 2, enable-low cycles after grant, before enable rises (≥1).
- GAP_CYC, 3, enable-low cycles after a burst, before the next arbitration (≥1).

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  level request per requester; held until done is seen.
- burst_len  in  N_REQ*LEN_W  packed burst lengths; requester i uses bits [i*LEN_W +: LEN_W].
- abort  in  1  terminates the current burst early.
- clk_enable  out  1  registered enable to the clock generator.
- grant  out  N_REQ  one-hot owner; all zero when no owner.
- done  out  N_REQ  one-cycle pulse to the owner when its burst ends.
- busy  out  1  high in any state other than IDLE.
- aborted  out  1  one-cycle pulse, coincident with done, when the burst ended by abort.

Behaviour:
- Reset:
  - Asynchronous reset is effective immediately at any point, including mid-burst.
  - State=IDLE; clk_enable=0, grant=0, done=0, busy=0, aborted=0.
  - Round-robin pointer = N_REQ-1, so requester 0 has first priority.
- States: IDLE, SETUP, RUN, GAP. All outputs are registered.
- IDLE:
  - If req≠0, pick the first set bit searching from ptr+1 upward with wrap-around.
  - Latch the winner's burst_len into len_q, set grant one-hot, set ptr=winner, load cnt=SETUP_CYC-1, go to SETUP.
  - Decision to grant visible: 1 cycle.
- SETUP:
  - clk_enable=0; grant held; cnt decrements.
  - At cnt==0:
    - len_q==0: go to GAP directly. done pulses to the owner in that same transition cycle, grant drops, and clk_enable never rises.
    - len_q≠0: load cnt=len_q-1, set clk_enable=1, go to RUN.
- RUN:
  - clk_enable=1 for exactly len_q cycles.
  - At cnt==0: clk_enable←0, done[owner] pulses, grant←0, load cnt=GAP_CYC-1, go to GAP.
- GAP:
  - clk_enable=0, grant=0; cnt decrements.
  - At cnt==0 go to IDLE. Arbitration happens on the following cycle, so back-to-back bursts are separated by ≥GAP_CYC+SETUP_CYC+1 enable-low cycles.
- abort:
  - Sampled in SETUP or RUN only.
  - Causes the same exit as RUN completion in the next cycle, plus aborted=1.
  - Ignored in IDLE and GAP.
- Requests and inputs:
  - Requester dropping req mid-burst has no effect; the burst runs to length.
  - Owner re-asserting req after done is arbitrated fairly; it gets lowest priority next round.
  - burst_len changes after grant are ignored because the length was latched.
- Counter and ptr widths:
  - cnt width = max(LEN_W, clog2(SETUP_CYC), clog2(GAP_CYC)).
  - No wrap: every count is loaded as length-1 and stops at 0.
  - ptr is clog2(N_REQ) bits; search is modulo N_REQ.
- Invariants:
  - grant is one-hot or zero.
  - clk_enable=1 implies grant≠0.
  - done and grant never have the owner bit set in the same cycle after RUN.

Decomposition:
- Shared package: state encoding localparams (IDLE=0, SETUP=1, RUN=2, GAP=3) and a clog2 function.
- One natural sub-module, rr_arbiter_onehot:
  - Combinational round-robin pick: req, ptr → one-hot winner plus valid.
  - Reused by the NoC router switch allocator.
- FSM, counters and output registers stay in the top module.

Test Plan:
- Single request: req=0001, len0=5 → grant[0] 1 cycle after req; clk_enable high exactly 5 cycles after 2 SETUP cycles; done[0] pulse at fall; busy low 3 GAP cycles later.
- Round-robin: req=1111 held, all len=2 → grant order 0,1,2,3,0; each pair of enable bursts separated by ≥6 low cycles.
- Zero length: req=0100, len2=0 → grant[2] for 2 cycles; clk_enable never rises; done[2] pulse; then GAP.
- Abort: len1=20, assert abort 4 cycles into RUN → clk_enable low next cycle; done[1] and aborted pulse together; GAP follows.
- Mid-burst reset: drop rst_n during RUN → clk_enable, grant and busy go 0 asynchronously; after release, req=1000 is granted (ptr reset, search 0..3, only 3 set).
- Request withdrawal / length change: deassert req[0] and change len0 during RUN → burst completes with the originally latched length.
